ram_burst_reader: RTL
=====================

// Module: ram_burst_reader
// PURPOSE
//  Read-side master for one port of the synchronous block RAM primitive. Accepts a burst request
//  (start address, word count), drives address/rden, and aligns the RAM's fixed read latency.
//  Delivers the words as a ready/valid stream with back-pressure and no data loss.
//  Sits between mapped RAM instances and downstream stream consumers (e.g. ROM/LUT table walkers).
// PARAMETERS
//  width      8  data word width; equals the RAM port width
//  widthad    8  address width; address space is 2**widthad words
//  rd_latency 1  RAM read latency in cycles, rden to mem_q valid; legal values 1 or 2
// PORTS
//  clock0      in   1          single clock; all logic on rising edge
//  aclr_n      in   1          asynchronous reset, active low
//  req_valid   in   1          burst request valid
//  req_ready   out  1          request accepted when req_valid & req_ready
//  req_addr    in   widthad    first word address
//  req_len     in   widthad+1  word count, 0..2**widthad
//  mem_address out  widthad    RAM address
//  mem_rden    out  1          RAM read enable; one read issued per high cycle
//  mem_q       in   width      RAM read data, valid rd_latency cycles after rden
//  out_valid   out  1          stream data valid
//  out_ready   in   1          stream sink ready
//  out_data    out  width      stream data
//  out_last    out  1          marks final word of burst
//  busy        out  1          burst in progress (state != IDLE)
//  done        out  1          one-cycle pulse at burst completion
// BEHAVIOUR
//  - Reset (aclr_n=0, async): state IDLE; all outputs 0 except req_ready=1. Counters, FIFO and
//    latency pipe are cleared. Reset mid-burst aborts; in-flight words are discarded, no done pulse.
//  - FSM IDLE -> ISSUE on accept with req_len>0. IDLE -> IDLE on accept with req_len=0;
//    done pulses the next cycle and no RAM access is made.
//  - FSM ISSUE -> DRAIN after the last read is issued.
//  - FSM DRAIN -> IDLE when the last word is accepted (out_valid & out_ready & out_last).
//    done pulses in the cycle after that acceptance.
//  - req_ready = (state==IDLE). Requests are never queued.
//  - Issue: in ISSUE, mem_rden=1 iff remaining>0 and (in_flight + fifo_count) < 4.
//    mem_address increments by 1 per issued read, modulo 2**widthad (wraps 2**widthad-1 -> 0).
//    When mem_rden=0, mem_address holds its last value.
//  - Latency pipe: a rd_latency-deep valid shift register tracks issued reads.
//    mem_q is written into a 4-entry output FIFO in the cycle its pipe bit emerges.
//  - Credit rule: the FIFO can never overflow; the credit check guarantees one free slot per in-flight read.
//  - Timing: accept at cycle T gives first mem_rden at T+1 and first out_valid at T+2+rd_latency.
//  - With out_ready held 1, throughput is 1 word/cycle sustained. A burst of N words has
//    its last word accepted at T+1+rd_latency+N.
//  - Stream: out_data/out_last are held stable while out_valid & !out_ready.
//    out_valid is not retracted until the word is accepted.
//  - out_last=1 only on word index req_len-1. A burst of length 1 has out_last on its only word.
//  - Simultaneous FIFO push and pop in one cycle are both performed; fifo_count is unchanged.
//  - req_len = 2**widthad reads every address exactly once, starting at req_addr and wrapping.
// TESTING
//  1 Reset: aclr_n=0 mid-burst with 3 words in flight -> outputs 0, req_ready=1 immediately.
//    No done pulse; the next burst streams correct data.
//  2 RAM preloaded mem[i]=i, req_addr=0x10, req_len=4, out_ready=1, rd_latency=1 -> out_data 10,11,12,13.
//    Expected timing: out_valid T+3..T+6, out_last with 0x13, done at T+7.
//  3 Wrap: req_addr=0xFE, req_len=4 -> mem_address FE,FF,00,01; out_data FE,FF,00,01.
//  4 Back-pressure: req_len=16, out_ready toggles 1,0,0,1 with rd_latency=2.
//    Required: FIFO never >4, in_flight+fifo_count<=4 every cycle, all 16 words in order.
//  5 req_len=0 -> mem_rden stays 0, done pulses at T+1, out_valid stays 0.
//  6 Back-to-back: second req_valid held during burst -> not accepted until IDLE.
//    Accepted the cycle after done deasserts busy; no words lost or duplicated.

Source files
------------

// File: rtl/ram_burst_reader_if.sv
// Bus bundle for ram_burst_reader: burst request, RAM read port and output stream.
// The master modport is the reader's view; slave is the view of whatever surrounds it.
interface ram_burst_reader_if #(
  parameter int width   = 8,
  parameter int widthad = 8
);

  logic               req_valid;
  logic               req_ready;
  logic [widthad-1:0] req_addr;
  logic [widthad:0]   req_len;
  logic [widthad-1:0] mem_address;
  logic               mem_rden;
  logic [width-1:0]   mem_q;
  logic               out_valid;
  logic               out_ready;
  logic [width-1:0]   out_data;
  logic               out_last;
  logic               busy;
  logic               done;

  modport master (
    input  req_valid, req_addr, req_len, mem_q, out_ready,
    output req_ready, mem_address, mem_rden, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output req_valid, req_addr, req_len, mem_q, out_ready,
    input  req_ready, mem_address, mem_rden, out_valid, out_data, out_last, busy, done
  );

endinterface

// File: rtl/ram_burst_reader.sv
// Burst read master for a synchronous block RAM port: issues reads under a credit limit,
// realigns the fixed RAM read latency and delivers the words as a ready/valid stream.
module ram_burst_reader #(
  parameter int width      = 8,
  parameter int widthad    = 8,
  parameter int rd_latency = 1
) (
  input logic                clock0,
  input logic                aclr_n,
  ram_burst_reader_if.master bus
);

  localparam int fifo_depth = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [widthad-1:0] next_addr_q, next_addr_d;
  logic [widthad-1:0] last_addr_q, last_addr_d;
  logic [widthad:0]   remaining_q, remaining_d;
  logic [widthad:0]   out_left_q, out_left_d;
  logic [rd_latency-1:0] pipe_q, pipe_d;
  logic [width-1:0]   fifo_q [fifo_depth];
  logic [width-1:0]   fifo_d [fifo_depth];
  logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]         count_q, count_d;
  logic               done_q, done_d;

  logic [2:0] in_flight;
  logic       accept, rden, push, pop, out_valid, out_last;

  // Every read in the latency pipe owns one FIFO slot, so issuing only while
  // pipe + FIFO occupancy is below the depth means the FIFO cannot overflow.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < rd_latency; i++) begin
      in_flight = in_flight + 3'(pipe_q[i]);
    end
    accept    = bus.req_valid && (state_q == IDLE);
    rden      = (state_q == ISSUE) && (remaining_q != '0) && ((in_flight + count_q) < 3'd4);
    push      = pipe_q[rd_latency-1];
    out_valid = (count_q != 3'd0);
    pop       = out_valid && bus.out_ready;
    out_last  = out_valid && (out_left_q == (widthad+1)'(1));
  end

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    last_addr_d = last_addr_q;
    remaining_d = remaining_q;
    out_left_d  = out_left_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          next_addr_d = bus.req_addr;
          remaining_d = bus.req_len;
          out_left_d  = bus.req_len;
          if (bus.req_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (rden && (remaining_q == (widthad+1)'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rden) begin
      last_addr_d = next_addr_q;
      next_addr_d = next_addr_q + widthad'(1);
      remaining_d = remaining_q - (widthad+1)'(1);
    end
    if (pop) begin
      out_left_d = out_left_q - (widthad+1)'(1);
    end
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = rden;
    for (int i = 1; i < rd_latency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    for (int i = 0; i < fifo_depth; i++) begin
      fifo_d[i] = fifo_q[i];
    end
    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_q;
    end
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock0 or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      last_addr_q <= '0;
      remaining_q <= '0;
      out_left_q  <= '0;
      pipe_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < fifo_depth; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      last_addr_q <= last_addr_d;
      remaining_q <= remaining_d;
      out_left_q  <= out_left_d;
      pipe_q      <= pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      done_q      <= done_d;
      fifo_q      <= fifo_d;
    end
  end

  // The address presented with a read is the next one; between reads it parks on the last.
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.mem_rden    = rden;
  assign bus.mem_address = rden ? next_addr_q : last_addr_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_last    = out_last;
  assign bus.out_data    = out_valid ? fifo_q[rd_ptr_q] : '0;

endmodule
